// File: rtl/throw_sequencer_pkg.sv
// Shared types, widths and arithmetic helpers for the throw sequencer.
package throw_sequencer_pkg;

   localparam int POS_W    = 13;
   localparam int SCORE_W  = 8;
   localparam int CNT_W    = 8;
   localparam int THROWS_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      AIM       = 3'd1,
      FLIGHT    = 3'd2,
      SETTLE    = 3'd3,
      JUDGE     = 3'd4,
      DONE      = 3'd5,
      GAME_OVER = 3'd6
   } seq_state_t;

   // Score addition that clamps at the all-ones value instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[SCORE_W]) begin
         return {SCORE_W{1'b1}};
      end else begin
         return sum[SCORE_W-1:0];
      end
   endfunction

   // |a - b| computed one bit wider than the operands so it cannot overflow.
   function automatic logic [POS_W:0] abs_diff(input logic signed [POS_W-1:0] a,
                                               input logic signed [POS_W-1:0] b);
      logic [POS_W:0] d;
      d = {a[POS_W-1], a} - {b[POS_W-1], b};
      if (d[POS_W]) begin
         return (~d) + {{POS_W{1'b0}}, 1'b1};
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/throw_sequencer_if.sv
// Link between the throw sequencer and the ball-motion block.
interface throw_sequencer_if;
   import throw_sequencer_pkg::*;

   logic                    z_neg;
   logic signed [POS_W-1:0] x_pos;
   logic signed [POS_W-1:0] y_pos;
   logic                    launch;
   logic                    en_collision;
   logic                    collision_done;

   // Sequencer side: controls the motion block, observes the ball.
   modport master (
      input  z_neg, x_pos, y_pos,
      output launch, en_collision, collision_done
   );

   // Motion side: reports the ball, obeys the controls.
   modport slave (
      output z_neg, x_pos, y_pos,
      input  launch, en_collision, collision_done
   );

endinterface

// File: rtl/throw_sequencer_hit_judge.sv
// Combinational hit test: ball inside the square box around the target.
module throw_sequencer_hit_judge
   import throw_sequencer_pkg::*;
#(
   parameter int HIT_RADIUS = 40
) (
   input  logic signed [POS_W-1:0] x_pos,
   input  logic signed [POS_W-1:0] y_pos,
   input  logic signed [POS_W-1:0] target_x,
   input  logic signed [POS_W-1:0] target_y,
   input  logic                    forced_miss,
   output logic                    hit
);

   localparam logic [POS_W:0] RADIUS_C = (POS_W+1)'(HIT_RADIUS);

   logic [POS_W:0] abs_dx_s;
   logic [POS_W:0] abs_dy_s;

   // Box comparison on sign-extended absolute differences; a timeout overrides.
   always_comb begin
      abs_dx_s = abs_diff(x_pos, target_x);
      abs_dy_s = abs_diff(y_pos, target_y);
      hit      = (abs_dx_s <= RADIUS_C) && (abs_dy_s <= RADIUS_C) && !forced_miss;
   end

endmodule

// File: rtl/throw_sequencer.sv
// Game-round controller: aim, launch, flight, settle, judge, score, re-arm.
module throw_sequencer
   import throw_sequencer_pkg::*;
#(
   parameter int THROWS_PER_GAME = 5,
   parameter int SETTLE_FRAMES   = 30,
   parameter int FLIGHT_TIMEOUT  = 255,
   parameter int HIT_RADIUS      = 40,
   parameter int POINTS          = 10
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_refresh,
   input  logic                    i_mouse_left,
   input  logic                    i_new_game,
   input  logic signed [POS_W-1:0] i_target_x,
   input  logic signed [POS_W-1:0] i_target_y,
   throw_sequencer_if.master       mot,
   output logic                    o_hit,
   output logic [SCORE_W-1:0]      o_score,
   output logic [THROWS_W-1:0]     o_throws_left,
   output logic                    o_game_over,
   output logic [2:0]              o_state
);

   localparam logic [THROWS_W-1:0] THROWS_C  = THROWS_W'(THROWS_PER_GAME);
   localparam logic [CNT_W-1:0]    TMO_LAST_C = CNT_W'(FLIGHT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    SET_LAST_C = CNT_W'(SETTLE_FRAMES - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX_C  = {CNT_W{1'b1}};
   localparam logic [SCORE_W-1:0]  POINTS_C   = SCORE_W'(POINTS);

   seq_state_t            state_r;
   seq_state_t            next_state_s;
   logic                  mouse_r;
   logic                  rise_s;
   logic                  fall_s;
   logic [CNT_W-1:0]      cnt_r;
   logic                  cnt_clr_s;
   logic                  cnt_inc_s;
   logic                  timeout_s;
   logic                  forced_miss_r;
   logic                  hit_s;
   logic                  hit_r;
   logic [SCORE_W-1:0]    score_r;
   logic [THROWS_W-1:0]   throws_r;
   logic                  launch_r;
   logic                  en_collision_r;
   logic                  collision_done_r;
   logic                  game_over_r;

   assign rise_s = i_mouse_left & ~mouse_r;
   assign fall_s = ~i_mouse_left & mouse_r;

   throw_sequencer_hit_judge #(
      .HIT_RADIUS (HIT_RADIUS)
   ) u_hit_judge (
      .x_pos       (mot.x_pos),
      .y_pos       (mot.y_pos),
      .target_x    (i_target_x),
      .target_y    (i_target_y),
      .forced_miss (forced_miss_r),
      .hit         (hit_s)
   );

   // State register and registered copy of the mouse level for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
         mouse_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         mouse_r <= i_mouse_left;
      end
   end

   // Next-state decode plus frame-counter and timeout controls.
   always_comb begin
      next_state_s = state_r;
      cnt_clr_s    = 1'b0;
      cnt_inc_s    = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               next_state_s = AIM;
            end else begin
               next_state_s = IDLE;
            end
         end
         AIM: begin
            if (fall_s) begin
               next_state_s = FLIGHT;
               cnt_clr_s    = 1'b1;
            end else begin
               next_state_s = AIM;
            end
         end
         FLIGHT: begin
            // A timeout on the same tick as landing still counts as a miss.
            if (i_refresh && (cnt_r >= TMO_LAST_C)) begin
               next_state_s = JUDGE;
               timeout_s    = 1'b1;
            end else if (mot.z_neg) begin
               next_state_s = SETTLE;
               cnt_clr_s    = 1'b1;
            end else begin
               next_state_s = FLIGHT;
               cnt_inc_s    = i_refresh;
            end
         end
         SETTLE: begin
            if (i_refresh && (cnt_r >= SET_LAST_C)) begin
               next_state_s = JUDGE;
            end else begin
               next_state_s = SETTLE;
               cnt_inc_s    = i_refresh;
            end
         end
         JUDGE: begin
            next_state_s = DONE;
         end
         DONE: begin
            if (throws_r <= {{(THROWS_W-1){1'b0}}, 1'b1}) begin
               next_state_s = GAME_OVER;
            end else begin
               next_state_s = IDLE;
            end
         end
         GAME_OVER: begin
            next_state_s = GAME_OVER;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
      if (i_new_game) begin
         next_state_s = IDLE;
         cnt_clr_s    = 1'b1;
      end else begin
         next_state_s = next_state_s;
      end
   end

   // Saturating frame counter shared by flight and settle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s && (cnt_r != CNT_MAX_C)) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Forced-miss flag: set by a flight timeout, cleared at each new launch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         forced_miss_r <= 1'b0;
      end else if (i_new_game || (state_r == AIM && fall_s)) begin
         forced_miss_r <= 1'b0;
      end else if (timeout_s) begin
         forced_miss_r <= 1'b1;
      end
   end

   // Judgement result, score and throw budget.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hit_r    <= 1'b0;
         score_r  <= {SCORE_W{1'b0}};
         throws_r <= THROWS_C;
      end else if (i_new_game) begin
         hit_r    <= 1'b0;
         score_r  <= {SCORE_W{1'b0}};
         throws_r <= THROWS_C;
      end else if (state_r == JUDGE) begin
         hit_r <= hit_s;
         if (hit_s) begin
            score_r <= sat_add(score_r, POINTS_C);
         end
      end else if (state_r == DONE) begin
         throws_r <= throws_r - {{(THROWS_W-1){1'b0}}, 1'b1};
      end
   end

   // Control outputs registered from the next state so they align with o_state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         launch_r         <= 1'b0;
         en_collision_r   <= 1'b0;
         collision_done_r <= 1'b0;
         game_over_r      <= 1'b0;
      end else begin
         launch_r         <= (next_state_s == AIM);
         en_collision_r   <= (next_state_s == SETTLE);
         collision_done_r <= i_new_game || (next_state_s == DONE);
         game_over_r      <= (next_state_s == GAME_OVER);
      end
   end

   assign mot.launch         = launch_r;
   assign mot.en_collision   = en_collision_r;
   assign mot.collision_done = collision_done_r;
   assign o_hit              = hit_r;
   assign o_score            = score_r;
   assign o_throws_left      = throws_r;
   assign o_game_over        = game_over_r;
   assign o_state            = state_r;

endmodule

// File: tb/tb_throw_sequencer.sv
// Scoreboard bench: two sequencers (default, and a high-points variant for
// saturation) share one stimulus stream; a monitor checks every collision_done.
module tb_throw_sequencer;
   import throw_sequencer_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic       hit;
      logic [7:0] score;
      logic [3:0] throws;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic refresh = 1'b0;
   logic mouse = 1'b0;
   logic new_game = 1'b0;
   logic z_neg = 1'b0;
   logic signed [12:0] x_pos = 13'sd0;
   logic signed [12:0] y_pos = 13'sd0;
   logic signed [12:0] tgt_x = 13'sd120;
   logic signed [12:0] tgt_y = 13'sd70;

   logic       hit1, hit2, go1, go2;
   logic [7:0] score1, score2;
   logic [3:0] thr1, thr2;
   logic [2:0] st1, st2;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int m_score1, m_score2, m_thr1, m_thr2;

   throw_sequencer_if mif1 ();
   throw_sequencer_if mif2 ();

   assign mif1.z_neg = z_neg;
   assign mif1.x_pos = x_pos;
   assign mif1.y_pos = y_pos;
   assign mif2.z_neg = z_neg;
   assign mif2.x_pos = x_pos;
   assign mif2.y_pos = y_pos;

   throw_sequencer dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_refresh(refresh), .i_mouse_left(mouse),
      .i_new_game(new_game), .i_target_x(tgt_x), .i_target_y(tgt_y), .mot(mif1),
      .o_hit(hit1), .o_score(score1), .o_throws_left(thr1), .o_game_over(go1),
      .o_state(st1)
   );

   throw_sequencer #(.THROWS_PER_GAME(15), .POINTS(100)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_refresh(refresh), .i_mouse_left(mouse),
      .i_new_game(new_game), .i_target_x(tgt_x), .i_target_y(tgt_y), .mot(mif2),
      .o_hit(hit2), .o_score(score2), .o_throws_left(thr2), .o_game_over(go2),
      .o_state(st2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      tick(1);
      refresh = 1'b0;
      tick(1);
   endtask

   function automatic int sat(input int s);
      return (s > 255) ? 255 : s;
   endfunction

   // Record the DONE-cycle view expected from both sequencers for one throw.
   task automatic expect_throw(input logic hit_exp, input logic in1);
      if (in1) begin
         if (hit_exp) m_score1 = sat(m_score1 + 10);
         q1.push_back('{st: 3'd5, hit: hit_exp, score: 8'(m_score1), throws: 4'(m_thr1)});
         m_thr1--;
      end
      if (hit_exp) m_score2 = sat(m_score2 + 100);
      q2.push_back('{st: 3'd5, hit: hit_exp, score: 8'(m_score2), throws: 4'(m_thr2)});
      m_thr2--;
   endtask

   // Press for three cycles and release; the ends up in FLIGHT.
   task automatic press_release(input logic check_launch);
      mouse = 1'b1;
      tick(1);
      if (check_launch) begin
         chk("aim_state", int'(st1), 1);
         chk("aim_launch", int'(mif1.launch), 1);
      end
      tick(2);
      if (check_launch) chk("aim_launch_held", int'(mif1.launch), 1);
      mouse = 1'b0;
      tick(1);
      if (check_launch) begin
         chk("flight_state", int'(st1), 2);
         chk("flight_launch", int'(mif1.launch), 0);
      end
   endtask

   // mode 0: land at (x,y); 1: never land; 2: land on the timeout tick.
   task automatic do_throw(input logic signed [12:0] x, input logic signed [12:0] y,
                           input int mode, input logic hit_exp);
      expect_throw(hit_exp, 1'b1);
      chk("idle_launch", int'(mif1.launch), 0);
      press_release(1'b1);
      x_pos = x;
      y_pos = y;
      if (mode == 0) begin
         repeat (5) pulse_refresh();
         z_neg = 1'b1;
         tick(1);
         z_neg = 1'b0;
         chk("settle_state", int'(st1), 3);
         chk("settle_en_coll", int'(mif1.en_collision), 1);
         repeat (29) pulse_refresh();
         chk("settle_hold", int'(st1), 3);
         pulse_refresh();
      end else if (mode == 1) begin
         repeat (254) pulse_refresh();
         chk("flight_before_timeout", int'(st1), 2);
         pulse_refresh();
      end else begin
         repeat (254) pulse_refresh();
         refresh = 1'b1;
         z_neg = 1'b1;
         tick(1);
         refresh = 1'b0;
         z_neg = 1'b0;
         chk("same_tick_judge", int'(st1), 4);
      end
      tick(3);
   endtask

   // Monitor for the default sequencer.
   always @(negedge clk) begin
      if (rst_n && mif1.collision_done) begin
         if (q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut1_unexpected_done: got pulse in state %0d, expected none", st1);
         end else begin
            e1 = q1.pop_front();
            chk("dut1_state", int'(st1), int'(e1.st));
            chk("dut1_hit", int'(hit1), int'(e1.hit));
            chk("dut1_score", int'(score1), int'(e1.score));
            chk("dut1_throws", int'(thr1), int'(e1.throws));
         end
      end
   end

   // Monitor for the high-points sequencer.
   always @(negedge clk) begin
      if (rst_n && mif2.collision_done) begin
         if (q2.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut2_unexpected_done: got pulse in state %0d, expected none", st2);
         end else begin
            e2 = q2.pop_front();
            chk("dut2_state", int'(st2), int'(e2.st));
            chk("dut2_hit", int'(hit2), int'(e2.hit));
            chk("dut2_score", int'(score2), int'(e2.score));
            chk("dut2_throws", int'(thr2), int'(e2.throws));
         end
      end
   end

   task automatic check_reset_values();
      chk("rst_state", int'(st1), 0);
      chk("rst_launch", int'(mif1.launch), 0);
      chk("rst_en_coll", int'(mif1.en_collision), 0);
      chk("rst_coll_done", int'(mif1.collision_done), 0);
      chk("rst_hit", int'(hit1), 0);
      chk("rst_score", int'(score1), 0);
      chk("rst_throws", int'(thr1), 5);
      chk("rst_game_over", int'(go1), 0);
   endtask

   initial begin
      m_score1 = 0; m_score2 = 0; m_thr1 = 5; m_thr2 = 15;
      tick(2);
      check_reset_values();
      rst_n = 1'b1;
      tick(2);

      // Game 1: hit, miss, timeout miss, same-tick miss, boundary hit.
      do_throw(13'sd100, 13'sd50, 0, 1'b1);
      do_throw(13'sd200, 13'sd50, 0, 1'b0);
      do_throw(13'sd120, 13'sd70, 1, 1'b0);
      do_throw(13'sd120, 13'sd70, 2, 1'b0);
      do_throw(13'sd160, 13'sd110, 0, 1'b1);
      chk("go_flag", int'(go1), 1);
      chk("go_state", int'(st1), 6);
      chk("go_throws", int'(thr1), 0);
      chk("go_score", int'(score1), 20);

      // Clicks after game over are ignored by the default sequencer.
      press_release(1'b0);
      tick(2);
      chk("go_click_state", int'(st1), 6);
      chk("go_click_launch", int'(mif1.launch), 0);

      // New game aborts both; each emits one collision_done pulse.
      q1.push_back('{st: 3'd0, hit: 1'b0, score: 8'd0, throws: 4'd5});
      q2.push_back('{st: 3'd0, hit: 1'b0, score: 8'd0, throws: 4'd15});
      new_game = 1'b1;
      tick(1);
      new_game = 1'b0;
      tick(1);
      chk("ng_state", int'(st1), 0);
      chk("ng_game_over", int'(go1), 0);
      chk("ng_score", int'(score1), 0);
      chk("ng_throws", int'(thr1), 5);
      chk("ng_pulse_ends", int'(mif1.collision_done), 0);
      chk("ng_dut2_state", int'(st2), 0);
      m_score1 = 0; m_score2 = 0; m_thr1 = 5; m_thr2 = 15;

      // Four hits: 10,20,30,40 for the default; 100,200,255,255 saturated.
      repeat (4) do_throw(13'sd120, 13'sd70, 0, 1'b1);
      chk("sat_score2", int'(score2), 255);

      // Reset during SETTLE returns everything to reset values at once.
      press_release(1'b0);
      repeat (3) pulse_refresh();
      z_neg = 1'b1;
      tick(1);
      z_neg = 1'b0;
      repeat (5) pulse_refresh();
      chk("pre_rst_settle", int'(st1), 3);
      rst_n = 1'b0;
      #1;
      check_reset_values();
      tick(2);
      rst_n = 1'b1;
      tick(2);

      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
